// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared constants for the GPIO register controller: the register map
// seen on the CPU data bus and the default port width.
// No ports.
package gpio_pkg;

  localparam int GPIO_WIDTH = 16;

  localparam logic [2:0] ADDR_DIR   = 3'd0;
  localparam logic [2:0] ADDR_OUT   = 3'd1;
  localparam logic [2:0] ADDR_IN    = 3'd2;
  localparam logic [2:0] ADDR_SET   = 3'd3;
  localparam logic [2:0] ADDR_CLR   = 3'd4;
  localparam logic [2:0] ADDR_IEN   = 3'd5;
  localparam logic [2:0] ADDR_ISTAT = 3'd6;
  localparam logic [2:0] ADDR_TGL   = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
// Two-flop synchroniser for the asynchronous pin inputs, a previous-value
// flop and a rising-edge detector. A 2-bit saturating prime counter blanks
// the edge output for the first cycles after reset release, so that a pin
// which is already high then does not look like a rising edge.
// The synchroniser depth is fixed at two stages.
//
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous active-high reset
//   i_pins  raw pin values, asynchronous to i_clk
//   o_sync  synchronised pin values (second stage)
//   o_edge  per-bit rising-edge pulse, masked until primed
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int N = GPIO_WIDTH - 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [N:0] i_pins,
  output logic [N:0] o_sync,
  output logic [N:0] o_edge
);

  logic [N:0] sync1_q;
  logic [N:0] sync2_q;
  logic [N:0] prev_q;
  logic [1:0] prime_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      prime_q <= 2'd0;
    end else begin
      sync1_q <= i_pins;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (prime_q != 2'd3) begin
        prime_q <= prime_q + 2'd1;
      end
    end
  end

  // prev only holds real pin history once the counter reaches 3; before
  // that, sync2 & ~prev would report pins that were high at reset release.
  assign o_sync = sync2_q;
  assign o_edge = (prime_q == 2'd3) ? (sync2_q & ~prev_q) : '0;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl
// Memory-mapped controller for one GPIO port. Holds the direction and
// output registers that drive the port, reads back the synchronised pins,
// latches rising edges into a sticky status register and raises a level
// interrupt for enabled status bits.
//
// Build option: GPIO_CTRL_TOGGLE_EN turns address 7 into a write-only
// toggle register (OUT ^= wdata). Without it address 7 is reserved.
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous active-high reset
//   i_addr           register select
//   i_wdata          write data
//   i_we / i_re      single-cycle write / read strobes
//   o_rdata          registered read data, held between reads
//   o_rvalid         one-cycle pulse the cycle after i_re
//   o_data_dir       direction to the port, 1 = output
//   o_data_transmit  output data to the port
//   i_data_received  pin data from the port, asynchronous
//   o_irq            level interrupt, |(ISTAT & IEN)
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int N = GPIO_WIDTH - 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_addr,
  input  logic [N:0] i_wdata,
  input  logic       i_we,
  input  logic       i_re,
  output logic [N:0] o_rdata,
  output logic       o_rvalid,
  output logic [N:0] o_data_dir,
  output logic [N:0] o_data_transmit,
  input  logic [N:0] i_data_received,
  output logic       o_irq
);

  logic [N:0] dir_q;
  logic [N:0] out_q;
  logic [N:0] ien_q;
  logic [N:0] istat_q;
  logic [N:0] pins_sync;
  logic [N:0] pins_edge;
  logic [N:0] w1c_mask;
  logic [N:0] rd_mux;

  gpio_sync_edge #(.N(N)) u_sync_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pins (i_data_received),
    .o_sync (pins_sync),
    .o_edge (pins_edge)
  );

  assign w1c_mask = (i_we && (i_addr == ADDR_ISTAT)) ? i_wdata : '0;

  // Read mux sees pre-edge register values, so a same-cycle write and read
  // at one address returns the old contents.
  always_comb begin
    rd_mux = '0;
    case (i_addr)
      ADDR_DIR:   rd_mux = dir_q;
      ADDR_OUT:   rd_mux = out_q;
      ADDR_IN:    rd_mux = pins_sync;
      ADDR_IEN:   rd_mux = ien_q;
      ADDR_ISTAT: rd_mux = istat_q;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dir_q    <= '0;
      out_q    <= '0;
      ien_q    <= '0;
      istat_q  <= '0;
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= i_re;
      if (i_re) begin
        o_rdata <= rd_mux;
      end

      if (i_we) begin
        case (i_addr)
          ADDR_DIR: dir_q <= i_wdata;
          ADDR_OUT: out_q <= i_wdata;
          ADDR_SET: out_q <= out_q | i_wdata;
          ADDR_CLR: out_q <= out_q & ~i_wdata;
          ADDR_IEN: ien_q <= i_wdata;
`ifdef GPIO_CTRL_TOGGLE_EN
          ADDR_TGL: out_q <= out_q ^ i_wdata;
`endif
          default: ;
        endcase
      end

      // A new edge overrides a simultaneous write-1-to-clear.
      istat_q <= (istat_q & ~w1c_mask) | pins_edge;
    end
  end

  assign o_data_dir      = dir_q;
  assign o_data_transmit = out_q;
  assign o_irq           = |(istat_q & ien_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
module tb_gpio_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [2:0]  i_addr = '0;
  logic [15:0] i_wdata = '0;
  logic        i_we = 1'b0;
  logic        i_re = 1'b0;
  logic [15:0] o_rdata;
  logic        o_rvalid;
  logic [15:0] o_data_dir;
  logic [15:0] o_data_transmit;
  logic [15:0] i_data_received = '0;
  logic        o_irq;

  gpio_ctrl #(.N(15)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_addr          (i_addr),
    .i_wdata         (i_wdata),
    .i_we            (i_we),
    .i_re            (i_re),
    .o_rdata         (o_rdata),
    .o_rvalid        (o_rvalid),
    .o_data_dir      (o_data_dir),
    .o_data_transmit (o_data_transmit),
    .i_data_received (i_data_received),
    .o_irq           (o_irq)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pin samples indexed by clock edge since reset release.
  // A pin level sampled at edge j shows in IN two edges later; a 0->1
  // change between edges j-1 and j lands in ISTAT at edge j+2, but only
  // for edges from 4 on (history before that is blanked).
  logic [15:0] hist [0:8191];
  int          m_edge;
  logic [15:0] m_dir, m_out, m_ien, m_istat, m_rdata;
  logic        m_rvalid;
  logic [15:0] pins;

  function automatic logic [15:0] pin_at(input int i);
    return (i <= 0) ? 16'h0 : hist[i];
  endfunction

  task automatic model_reset();
    m_edge = 0;
    m_dir = '0; m_out = '0; m_ien = '0; m_istat = '0; m_rdata = '0;
    m_rvalid = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic re, input logic [2:0] a,
                            input logic [15:0] w);
    logic [15:0] rise, clr;
    m_edge++;
    hist[m_edge] = pins;
    if (re) begin
      case (a)
        3'd0: m_rdata = m_dir;
        3'd1: m_rdata = m_out;
        3'd2: m_rdata = pin_at(m_edge - 2);
        3'd5: m_rdata = m_ien;
        3'd6: m_rdata = m_istat;
        default: m_rdata = 16'h0;
      endcase
    end
    m_rvalid = re;
    rise = (m_edge >= 4) ? (pin_at(m_edge - 2) & ~pin_at(m_edge - 3)) : 16'h0;
    clr = 16'h0;
    if (we) begin
      case (a)
        3'd0: m_dir = w;
        3'd1: m_out = w;
        3'd3: m_out = m_out | w;
        3'd4: m_out = m_out & ~w;
        3'd5: m_ien = w;
        3'd6: clr = w;
`ifdef GPIO_CTRL_TOGGLE_EN
        3'd7: m_out = m_out ^ w;
`endif
        default: ;
      endcase
    end
    m_istat = (m_istat & ~clr) | rise;
  endtask

  task automatic check_all();
    check("dir", o_data_dir, m_dir);
    check("transmit", o_data_transmit, m_out);
    check("irq", o_irq, |(m_istat & m_ien));
    check("rvalid", o_rvalid, m_rvalid);
    check("rdata", o_rdata, m_rdata);
  endtask

  task automatic step(input logic we, input logic re, input logic [2:0] a,
                      input logic [15:0] w);
    i_we = we; i_re = re; i_addr = a; i_wdata = w; i_data_received = pins;
    @(posedge i_clk);
    model_edge(we, re, a, w);
    #1;
    check_all();
    i_we = 1'b0; i_re = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic do_reset();
    i_we = 1'b0; i_re = 1'b0;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    model_reset();
    check_all();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    model_reset();

    // Pins already high at reset release must not register as edges.
    pins = 16'hFFFF;
    i_data_received = pins;
    do_reset();
    idle(6);
    step(1'b0, 1'b1, 3'd6, 16'h0);
    check("istat_after_release", o_rdata, 16'h0000);
    check("irq_after_release", o_irq, 1'b0);
    step(1'b0, 1'b1, 3'd2, 16'h0);
    check("in_read", o_rdata, 16'hFFFF);
    check("in_rvalid", o_rvalid, 1'b1);
    idle(1);
    check("rvalid_drop", o_rvalid, 1'b0);

    // Direction / output / set / clear.
    pins = 16'h0000;
    idle(4);
    step(1'b1, 1'b0, 3'd0, 16'h00FF);
    step(1'b1, 1'b0, 3'd1, 16'hAAAA);
    step(1'b1, 1'b0, 3'd3, 16'h0005);
    step(1'b1, 1'b0, 3'd4, 16'h0008);
    check("dir_port", o_data_dir, 16'h00FF);
    check("out_port", o_data_transmit, 16'hAAA7);
    step(1'b0, 1'b1, 3'd1, 16'h0);
    check("out_read", o_rdata, 16'hAAA7);

    // Pin0 rise with IEN bit 0: irq exactly after edge k+2.
    step(1'b1, 1'b0, 3'd5, 16'h0001);
    pins = 16'h0001;
    idle(1);
    check("irq_k", o_irq, 1'b0);
    idle(1);
    check("irq_k1", o_irq, 1'b0);
    idle(1);
    check("irq_k2", o_irq, 1'b1);
    step(1'b1, 1'b0, 3'd6, 16'h0001);
    check("irq_w1c", o_irq, 1'b0);

    // Pin3 rise with IEN bit 3 off, then enable.
    pins = 16'h0009;
    idle(3);
    step(1'b0, 1'b1, 3'd6, 16'h0);
    check("istat3", o_rdata, 16'h0008);
    check("irq_masked", o_irq, 1'b0);
    step(1'b1, 1'b0, 3'd5, 16'h0008);
    check("irq_enable_pending", o_irq, 1'b1);

    // W1C of bit0 on the same edge a new bit0 edge lands.
    pins = 16'h0008;
    idle(3);
    pins = 16'h0009;
    idle(2);
    step(1'b1, 1'b0, 3'd6, 16'h0001);
    step(1'b0, 1'b1, 3'd6, 16'h0);
    check("set_wins", o_rdata, 16'h0009);

    // Address 7: toggle when built in, otherwise ignored; reads 0.
    step(1'b1, 1'b0, 3'd1, 16'h00F0);
    step(1'b1, 1'b0, 3'd7, 16'h0FF0);
`ifdef GPIO_CTRL_TOGGLE_EN
    check("tgl", o_data_transmit, 16'h0F00);
`else
    check("tgl", o_data_transmit, 16'h00F0);
`endif
    step(1'b0, 1'b1, 3'd7, 16'h0);
    check("addr7_read", o_rdata, 16'h0000);

    // Same-cycle write and read returns the old value.
    step(1'b1, 1'b1, 3'd0, 16'h1234);
    check("rw_same", o_rdata, 16'h00FF);

    // Reset in the middle of a read drops rvalid immediately.
    step(1'b0, 1'b1, 3'd0, 16'h0);
    #2 i_rst = 1'b1;
    #1;
    check("rst_rvalid", o_rvalid, 1'b0);
    check("rst_dir", o_data_dir, 16'h0000);
    check("rst_rdata", o_rdata, 16'h0000);
    do_reset();

    // Randomized traffic against the model.
    pins = $urandom;
    for (int i = 0; i < 2000; i++) begin
      logic [2:0]  a;
      logic [15:0] w;
      logic        we, re;
      if ($urandom_range(0, 3) == 0) pins = pins ^ ($urandom & $urandom);
      a  = 3'($urandom_range(0, 7));
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 2) == 0);
      w  = (a == 3'd6) ? 16'($urandom & $urandom) : 16'($urandom);
      step(we, re, a, w);
      if (i == 1000) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
